// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED PWM drive with saturating brightness ramps between pattern steps.
// Define LED_GAMMA_EN to map levels through a perceptual gamma curve; default is linear duty.
module led_pwm_fader #(
  parameter int N_LED    = 8,
  parameter int PWM_BITS = 4,
  parameter int FADE_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LED-1:0] pattern_in,
  input  logic             enable,
  output logic [N_LED-1:0] led_out,
  output logic             fade_busy
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int FW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);
`ifdef LED_GAMMA_EN
  localparam logic [63:0] GAMMA4 = 64'hFCA8_6543_2211_1000;
`endif
  logic [N_LED-1:0]    pattern_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FW-1:0]       fade_cnt;
  logic                fade_tick;
  logic [N_LED-1:0]    lit;
  logic [N_LED-1:0]    off_target;
  function automatic logic [PWM_BITS-1:0] duty(input logic [PWM_BITS-1:0] l);
`ifdef LED_GAMMA_EN
    if (l == MAX) return MAX;
    if (PWM_BITS == 4) return PWM_BITS'(GAMMA4[int'(l)*4 +: 4]);
    return PWM_BITS'((int'(l) * int'(l)) >> PWM_BITS);
`else
    return l;
`endif
  endfunction
  assign fade_tick = fade_cnt == FADE_LAST;
  assign fade_busy = |off_target;
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      led_out   <= '0;
    end else begin
      pattern_q <= pattern_in;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      fade_cnt  <= fade_tick ? '0 : fade_cnt + FW'(1);
      led_out   <= enable ? lit : '0;
    end
  end
  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] d;
    assign d = duty(level);
    assign lit[i] = (d == MAX) | (d > pwm_cnt);
    assign off_target[i] = level != (pattern_q[i] ? MAX : '0);
    // saturating ramp toward the target; a pattern flip just reverses direction
    always_ff @(posedge clk) begin
      if (reset)
        level <= '0;
      else if (fade_tick)
        level <= pattern_q[i] ? (level == MAX ? MAX : level + PWM_BITS'(1))
                              : (level == '0 ? '0 : level - PWM_BITS'(1));
    end
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: randomized and directed bench for led_pwm_fader against a behavioural model.
// Honours LED_GAMMA_EN the same way as the design.
module tb_led_pwm_fader;
  localparam int FD = 64;
  logic clk = 0, reset = 1, enable = 1;
  logic [7:0] pattern_in = 8'h00;
  logic [7:0] led_out;
  logic fade_busy;
  int errors = 0, checks = 0;
  int m_lvl [8];
  logic [7:0] m_pat, m_led;
  logic m_busy;
  int cyc;
  bit m_valid = 0;
`ifdef LED_GAMMA_EN
  int gam [16] = '{0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15};
  localparam int D5 = 1, D3 = 1;
  function automatic int duty(input int l); return gam[l]; endfunction
`else
  localparam int D5 = 5, D3 = 3;
  function automatic int duty(input int l); return l; endfunction
`endif

  led_pwm_fader #(.N_LED(8), .PWM_BITS(4), .FADE_DIV(FD)) dut (
    .clk(clk), .reset(reset), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_out), .fade_busy(fade_busy));

  always #5 clk = ~clk;

  // Model: time since reset drives both counters; levels move toward targets once per 64 cycles.
  always @(posedge clk) begin
    if (reset) begin
      cyc = 0; m_pat = 0; m_led = 0; m_valid = 1;
      for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++)
        m_led[i] = enable && (duty(m_lvl[i]) == 15 || duty(m_lvl[i]) > cyc % 16);
      if (cyc % FD == FD - 1)
        for (int i = 0; i < 8; i++)
          m_lvl[i] = m_pat[i] ? (m_lvl[i] < 15 ? m_lvl[i] + 1 : 15) : (m_lvl[i] > 0 ? m_lvl[i] - 1 : 0);
      m_pat = pattern_in;
      cyc++;
    end
    m_busy = 0;
    for (int i = 0; i < 8; i++) if (m_lvl[i] != (m_pat[i] ? 15 : 0)) m_busy = 1;
  end

  always @(negedge clk) if (m_valid) begin
    checks += 2;
    if (led_out !== m_led) begin
      errors++; $display("FAIL led_out t=%0t got %h want %h", $time, led_out, m_led);
    end
    if (fade_busy !== m_busy) begin
      errors++; $display("FAIL fade_busy t=%0t got %b want %b", $time, fade_busy, m_busy);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++; $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_lvl0(input int v, input int bound, output int n);
    n = 0;
    while (m_lvl[0] != v && n < bound) begin @(negedge clk); n++; end
    chk($sformatf("wait level0=%0d", v), m_lvl[0], v);
  endtask

  task automatic count_hi(output int cnt, output int others);
    cnt = 0; others = 0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      cnt += int'(led_out[0]);
      others |= int'(led_out[7:1]);
      @(negedge clk);
    end
  endtask

  initial begin
    int n, cnt, oth;
    pattern_in = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("reset led_out", int'(led_out), 0);
      chk("reset fade_busy", int'(fade_busy), 0);
    end
    reset = 0;
    @(negedge clk);
    chk("first cycle led_out", int'(led_out), 0);
    @(negedge clk);
    chk("busy after FF", int'(fade_busy), 1);
    n = 0;
    while (m_busy && n < 1100) begin @(negedge clk); n++; end
    chk("ramp to full idle", int'(m_busy), 0);
    repeat (2) @(negedge clk);
    chk("saturated led_out", int'(led_out), 255);
    chk("saturated busy", int'(fade_busy), 0);
    enable = 0;
    @(negedge clk);
    chk("disabled led_out", int'(led_out), 0);
    chk("disabled busy", int'(fade_busy), 0);
    enable = 1;
    @(negedge clk);
    chk("reenabled led_out", int'(led_out), 255);

    reset = 1; pattern_in = 8'h01;
    repeat (2) @(negedge clk);
    reset = 0;
    wait_lvl0(5, 400, n);
    chk("ticks to level 5", n, 5 * FD);
    count_hi(cnt, oth);
    chk("level5 high count", cnt, D5);
    chk("level5 other leds", oth, 0);
    pattern_in = 8'h00;
    for (int v = 4; v >= 0; v--) begin
      wait_lvl0(v, 70, n);
    end
    repeat (2) @(negedge clk);
    chk("faded out led0", int'(led_out[0]), 0);
    chk("faded out busy", int'(fade_busy), 0);

    for (int k = 0; k < 40; k++) begin
      pattern_in = 8'($urandom);
      enable = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(1, 200)) @(negedge clk);
    end

    enable = 1; reset = 1; pattern_in = 8'hFF;
    @(negedge clk);
    reset = 0;
    wait_lvl0(8, 600, n);
    reset = 1;
    @(negedge clk);
    chk("reset midramp led_out", int'(led_out), 0);
    reset = 0;
    wait_lvl0(3, 300, n);
    chk("restart ramp cycles", n, 3 * FD);
    count_hi(cnt, oth);
    chk("level3 high count", cnt, D3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
